mem_responder: RTL and testbench

Synthesizable word-addressed memory responder for the memory side of the multi-cycle CPU's `CPU_MIO` / `MIO_ready` bus. It serves instruction fetches and `lw`/`sw` accesses from an internal RAM, with a fixed programmable wait-state count. It replaces the behavioural address-to-data lookup used in simulation, so the CPU can run against realistic handshake timing. A side-band preload port lets a bench or boot loader fill the RAM before the CPU starts.

---
 rtl/mem_responder.sv | 120 ++++++++++++
 tb/tb_mem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the CPU_MIO / MIO_ready bus with a fixed
// wait-state count, error flagging and a side-band preload port.
module mem_responder #(
  parameter int ADDR_BITS   = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 CPU_MIO,
  input  logic                 mem_w,
  input  logic [31:0]          Addr_out,
  input  logic [31:0]          Data_out,
  output logic [31:0]          Data_in,
  output logic                 MIO_ready,
  output logic                 err,
  input  logic                 ld_we,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [31:0]          ld_data,
  output logic [15:0]          acc_cnt,
  output logic [1:0]           rsp_state
);

  // Bus handshake: the CPU holds CPU_MIO and its request fields stable until
  // it sees MIO_ready; MIO_ready is a single-cycle pulse in the ACK state, and
  // a CPU_MIO still high in the following IDLE cycle is a new request.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_t               state;
  state_t               state_nxt;
  logic [3:0]           wait_cnt;
  logic [3:0]           wait_cnt_nxt;
  logic                 commit;
  logic [ADDR_BITS-1:0] idx;
  logic                 bad;
  logic [31:0]          ram [2**ADDR_BITS];

  assign idx = Addr_out[ADDR_BITS+1:2];
  assign bad = (|Addr_out[1:0]) | (|Addr_out[31:ADDR_BITS+2]);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    commit       = 1'b0;
    case (state)
      S_IDLE: begin
        // A preload owns the edge; any concurrent request waits one edge.
        if (!ld_we && CPU_MIO) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_ACK;
            commit    = 1'b1;
          end else begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = S_ACK;
          commit    = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Data_in <= 32'd0;
      err     <= 1'b0;
      acc_cnt <= 16'd0;
    end else begin
      // err is only ever set on the commit edge, so it drops leaving ACK.
      err <= commit & bad;
      if (commit) begin
        acc_cnt <= acc_cnt + 16'd1;
        if (bad) begin
          Data_in <= 32'd0;
        end else if (!mem_w) begin
          Data_in <= ram[idx];
        end
      end
    end
  end

  // RAM contents survive reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_IDLE && ld_we) begin
        ram[ld_addr] <= ld_data;
      end else if (commit && mem_w && !bad) begin
        ram[idx] <= Data_out;
      end
    end
  end

  assign MIO_ready = (state == S_ACK);
  assign rsp_state = state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, zero-wait back-to-back traffic,
// corner sequences and randomized accesses against a memory model.
module tb_mem_responder;

  localparam int AB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          mio     [2];
  logic          mw      [2];
  logic [31:0]   addr    [2];
  logic [31:0]   wdata   [2];
  logic [31:0]   data_in [2];
  logic          ready   [2];
  logic          err     [2];
  logic          ld_we   [2];
  logic [AB-1:0] ld_addr [2];
  logic [31:0]   ld_data [2];
  logic [15:0]   acc     [2];
  logic [1:0]    st      [2];

  mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .CPU_MIO(mio[0]), .mem_w(mw[0]),
    .Addr_out(addr[0]), .Data_out(wdata[0]), .Data_in(data_in[0]),
    .MIO_ready(ready[0]), .err(err[0]), .ld_we(ld_we[0]),
    .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .acc_cnt(acc[0]),
    .rsp_state(st[0])
  );

  mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .CPU_MIO(mio[1]), .mem_w(mw[1]),
    .Addr_out(addr[1]), .Data_out(wdata[1]), .Data_in(data_in[1]),
    .MIO_ready(ready[1]), .err(err[1]), .ld_we(ld_we[1]),
    .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .acc_cnt(acc[1]),
    .rsp_state(st[1])
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: plain memory array, last read value and access count.
  logic [31:0] mem_m [2][64];
  logic [31:0] dat_m [2];
  logic [15:0] acc_m [2];
  int          wait_of [2] = '{2, 0};

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [15:0] exp_acc;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic preload(input int u, input int a, input logic [31:0] d);
    @(negedge clk);
    ld_we[u] = 1'b1; ld_addr[u] = AB'(a); ld_data[u] = d;
    @(negedge clk);
    ld_we[u] = 1'b0;
    mem_m[u][a] = d;
  endtask

  task automatic start_req(input int u, input logic we, input logic [31:0] a, input logic [31:0] d);
    mio[u] = 1'b1; mw[u] = we; addr[u] = a; wdata[u] = d;
  endtask

  task automatic model_access(input int u, input logic we, input logic [31:0] a,
                              input logic [31:0] d, output logic e);
    int i;
    i = int'(a / 4) % 64;
    if ((a % 4) != 0 || (a >> (AB + 2)) != 0) begin
      dat_m[u] = 32'd0;
      e = 1'b1;
    end else begin
      if (we) mem_m[u][i] = d;
      else    dat_m[u] = mem_m[u][i];
      e = 1'b0;
    end
    acc_m[u] = acc_m[u] + 16'd1;
  endtask

  // Returns at the falling edge inside the ACK cycle.
  task automatic wait_ack(input int u, input int exp_edges, input string name,
                          input logic exp_err, input logic [31:0] exp_data,
                          input logic [15:0] exp_acc);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ready[u]) seen = 1;
    end
    if (!seen) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_lat"},   n,           exp_edges);
      chk({name, "_data"},  data_in[u],  exp_data);
      chk({name, "_err"},   err[u],      exp_err);
      chk({name, "_acc"},   acc[u],      exp_acc);
      chk({name, "_state"}, st[u],       2'd2);
    end
  endtask

  task automatic finish_ack(input int u, input string name);
    mio[u] = 1'b0;
    @(negedge clk);
    chk({name, "_pulse"},  ready[u], 1'b0);
    chk({name, "_errclr"}, err[u],   1'b0);
  endtask

  task automatic access(input int u, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input string name);
    logic e;
    start_req(u, we, a, d);
    model_access(u, we, a, d, e);
    wait_ack(u, wait_of[u] + 1, name, e, dat_m[u], acc_m[u]);
    finish_ack(u, name);
  endtask

  initial begin
    logic e;
    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0,         32'h2008_000A, 1'b0, 16'd1};
    vecs[1] = '{1'b1, 32'h0000_0010, 32'h0000_000F, 32'h2008_000A, 1'b0, 16'd2};
    vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,         32'h0000_000F, 1'b0, 16'd3};
    vecs[3] = '{1'b0, 32'h0000_0006, 32'h0,         32'h0000_0000, 1'b1, 16'd4};
    vecs[4] = '{1'b1, 32'h0000_0400, 32'h0000_DEAD, 32'h0000_0000, 1'b1, 16'd5};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,         32'h2008_000A, 1'b0, 16'd6};
    vecs[6] = '{1'b0, 32'h0000_0004, 32'h0,         32'h2009_0005, 1'b0, 16'd7};
    vecs[7] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 32'h2009_0005, 1'b0, 16'd8};
    vecs[8] = '{1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b0, 16'd9};
    vecs[9] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0000_0000, 1'b1, 16'd10};

    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      mio[u] = 0; mw[u] = 0; addr[u] = 0; wdata[u] = 0;
      ld_we[u] = 0; ld_addr[u] = 0; ld_data[u] = 0;
      dat_m[u] = 0; acc_m[u] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_ready", ready[u], 1'b0);
      chk("rst_err",   err[u],   1'b0);
      chk("rst_data",  data_in[u], 32'd0);
      chk("rst_acc",   acc[u],   16'd0);
      chk("rst_state", st[u],    2'd0);
    end

    for (int u = 0; u < 2; u++)
      for (int w = 0; w < 64; w++) preload(u, w, $urandom);

    // Directed table on the two-wait-state instance.
    preload(0, 0, 32'h2008_000A);
    preload(0, 1, 32'h2009_0005);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start_req(0, vecs[i].we, vecs[i].a, vecs[i].d);
      model_access(0, vecs[i].we, vecs[i].a, vecs[i].d, e);
      wait_ack(0, 3, $sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_data, vecs[i].exp_acc);
      finish_ack(0, $sformatf("vec%0d", i));
    end

    // Zero-wait back-to-back with CPU_MIO held high and retargeted in ACK.
    preload(1, 0, 32'h0000_0111);
    preload(1, 1, 32'h0000_0222);
    preload(1, 2, 32'h0000_0333);
    @(negedge clk);
    start_req(1, 1'b0, 32'h0, 32'h0);
    model_access(1, 1'b0, 32'h0, 32'h0, e);
    wait_ack(1, 1, "b2b0", 1'b0, 32'h0000_0111, acc_m[1]);
    start_req(1, 1'b0, 32'h4, 32'h0);
    model_access(1, 1'b0, 32'h4, 32'h0, e);
    wait_ack(1, 2, "b2b1", 1'b0, 32'h0000_0222, acc_m[1]);
    start_req(1, 1'b0, 32'h8, 32'h0);
    model_access(1, 1'b0, 32'h8, 32'h0, e);
    wait_ack(1, 2, "b2b2", 1'b0, 32'h0000_0333, acc_m[1]);
    finish_ack(1, "b2b2");

    // Preload and request in the same IDLE cycle: load wins, request next edge.
    @(negedge clk);
    ld_we[0] = 1'b1; ld_addr[0] = AB'(5); ld_data[0] = 32'hC0FF_EE01;
    start_req(0, 1'b0, 32'h14, 32'h0);
    @(negedge clk);
    ld_we[0] = 1'b0;
    mem_m[0][5] = 32'hC0FF_EE01;
    chk("coll_idle", st[0], 2'd0);
    model_access(0, 1'b0, 32'h14, 32'h0, e);
    wait_ack(0, 3, "coll", 1'b0, 32'hC0FF_EE01, acc_m[0]);
    finish_ack(0, "coll");

    // Randomized mix of good, misaligned and out-of-range accesses.
    for (int i = 0; i < 150; i++) begin
      int u;
      int kind;
      logic [31:0] a;
      u = $urandom_range(0, 1);
      kind = $urandom_range(0, 7);
      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      if (kind == 6) a = a | 32'($urandom_range(1, 3));
      if (kind == 7) a = a | (32'd1 << $urandom_range(AB + 2, 31));
      if ($urandom_range(0, 9) == 0) preload(u, $urandom_range(0, 63), $urandom);
      @(negedge clk);
      access(u, 1'($urandom_range(0, 1)), a, $urandom, $sformatf("rnd%0d", i));
    end

    // Counter wrap: preset the counter to 65535 accesses, then one more.
    @(negedge clk);
    force dut.acc_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.acc_cnt;
    @(negedge clk);
    chk("wrap_preset", acc[0], 16'hFFFF);
    acc_m[0] = 16'hFFFF;
    access(0, 1'b0, 32'h0, 32'h0, "wrap");
    chk("wrap_zero", acc[0], 16'h0000);

    // Reset during WAIT of a write to word 2 aborts it.
    @(negedge clk);
    start_req(0, 1'b1, 32'h8, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("abort_wait", st[0], 2'd1);
    reset = 1'b1;
    #1;
    chk("abort_ready", ready[0], 1'b0);
    chk("abort_err",   err[0],   1'b0);
    chk("abort_data",  data_in[0], 32'd0);
    chk("abort_acc",   acc[0],   16'd0);
    chk("abort_state", st[0],    2'd0);
    mio[0] = 1'b0;
    @(negedge clk);
    chk("abort_noready", ready[0], 1'b0);
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      acc_m[u] = 16'd0;
      dat_m[u] = 32'd0;
    end
    chk("abort_acc1", acc[1], 16'd0);
    @(negedge clk);
    access(0, 1'b0, 32'h8, 32'h0, "abort_word2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
